// File: rtl/sram_controller_if.sv
// Data-memory request bus between the MEM stage and the SRAM controller.
// The master side raises a request and waits for ready; the slave side serves it.
interface sram_controller_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Serialises one 32-bit load/store into two 16-bit accesses on an asynchronous SRAM,
// holding ready low (pipeline freeze) until the access has finished.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  output logic [17:0]       sram_addr_o,
  output logic [15:0]       sram_dq_out_o,
  output logic              sram_dq_oe_o,
  input  logic [15:0]       sram_dq_in_i,
  output logic              sram_we_n_o
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] readData_q, readData_d;

  logic [31:0] offset;
  logic        lastPhase;
  logic        unusedOffsetBits;

  // Only the SRAM word index of the latched address is ever needed, so it is stored directly.
  assign offset           = bus.address - BASE_ADDR;
  assign unusedOffsetBits = ^{offset[31:19], offset[1:0]};
  assign lastPhase        = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      readData_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      readData_q <= readData_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    readData_d = readData_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_w_en || bus.mem_r_en) begin
          state_d = bus.mem_w_en ? WR_LO : RD_LO;
          cnt_d   = '0;
          word_d  = offset[18:2];
          wdata_d = bus.write_data;
        end
      end
      RD_LO: begin
        if (lastPhase) begin
          readData_d[15:0] = sram_dq_in_i;
          state_d          = RD_HI;
          cnt_d            = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_HI: begin
        if (lastPhase) begin
          readData_d[31:16] = sram_dq_in_i;
          state_d           = DONE;
          cnt_d             = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_LO: begin
        if (lastPhase) begin
          state_d = WR_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_HI: begin
        if (lastPhase) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are purely state-decoded so a reset edge releases the bus immediately.
  always_comb begin
    sram_addr_o   = '0;
    sram_dq_out_o = '0;
    sram_dq_oe_o  = 1'b0;
    sram_we_n_o   = 1'b1;
    case (state_q)
      RD_LO: sram_addr_o = {word_q, 1'b0};
      RD_HI: sram_addr_o = {word_q, 1'b1};
      WR_LO: begin
        sram_addr_o   = {word_q, 1'b0};
        sram_dq_out_o = wdata_q[15:0];
        sram_dq_oe_o  = 1'b1;
        sram_we_n_o   = 1'b0;
      end
      WR_HI: begin
        sram_addr_o   = {word_q, 1'b1};
        sram_dq_out_o = wdata_q[31:16];
        sram_dq_oe_o  = 1'b1;
        sram_we_n_o   = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.read_data = readData_q;
  assign bus.ready     = ((state_q == IDLE) && !bus.mem_r_en && !bus.mem_w_en) || (state_q == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES 2 and 1) with behavioural SRAMs,
// checked against a word-level memory model with directed and random transactions.
module tb_sram_controller;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int W0 = 2;
  localparam int W1 = 1;
  localparam int HW_DEPTH = 262144;
  localparam int WORD_DEPTH = 131072;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if busIf0();
  sram_controller_if busIf1();

  logic [17:0] sramAddr0, sramAddr1;
  logic [15:0] dqOut0, dqOut1, dqIn0, dqIn1;
  logic        oe0, oe1, weN0, weN1;

  sram_controller #(.WAIT_CYCLES(W0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst(rst), .bus(busIf0),
    .sram_addr_o(sramAddr0), .sram_dq_out_o(dqOut0), .sram_dq_oe_o(oe0),
    .sram_dq_in_i(dqIn0), .sram_we_n_o(weN0)
  );

  sram_controller #(.WAIT_CYCLES(W1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .bus(busIf1),
    .sram_addr_o(sramAddr1), .sram_dq_out_o(dqOut1), .sram_dq_oe_o(oe1),
    .sram_dq_in_i(dqIn1), .sram_we_n_o(weN1)
  );

  // Behavioural asynchronous SRAMs with a backdoor preload port.
  logic [15:0] sram0 [0:HW_DEPTH-1];
  logic [15:0] sram1 [0:HW_DEPTH-1];
  logic        preWe;
  logic [17:0] preAddr;
  logic [15:0] preData0, preData1;

  always @(posedge clk) begin
    if (preWe) begin
      sram0[preAddr] <= preData0;
      sram1[preAddr] <= preData1;
    end
    if (!weN0) sram0[sramAddr0] <= dqOut0;
    if (!weN1) sram1[sramAddr1] <= dqOut1;
  end

  assign dqIn0 = sram0[sramAddr0];
  assign dqIn1 = sram1[sramAddr1];

  // Reference model: a plain 32-bit word memory per instance plus the last load result.
  logic [31:0] shadow [0:1][0:WORD_DEPTH-1];
  logic [31:0] lastRead [0:1];
  logic [15:0] pre0 [0:127];
  logic [15:0] pre1 [0:127];

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic [17:0] addr;
    logic [15:0] dq;
    logic        oe;
    logic        weN;
  } obs_t;

  function automatic obs_t snap(input int s);
    obs_t o;
    if (s == 0) o = '{busIf0.ready, busIf0.read_data, sramAddr0, dqOut0, oe0, weN0};
    else        o = '{busIf1.ready, busIf1.read_data, sramAddr1, dqOut1, oe1, weN1};
    return o;
  endfunction

  function automatic int waitOf(input int s);
    return (s == 0) ? W0 : W1;
  endfunction

  function automatic int modelWord(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % WORD_DEPTH);
  endfunction

  function automatic logic [15:0] sramRd(input int s, input int idx);
    return (s == 0) ? sram0[idx] : sram1[idx];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(input int s, input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      busIf0.mem_r_en = re; busIf0.mem_w_en = we; busIf0.address = a; busIf0.write_data = d;
    end else begin
      busIf1.mem_r_en = re; busIf1.mem_w_en = we; busIf1.address = a; busIf1.write_data = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one request from a negedge in IDLE (or DONE when chained) and leaves it at the DONE negedge.
  task automatic applyStimulus(input int s, input bit re, input bit we, input logic [31:0] a,
                               input logic [31:0] d, input bit fromDone);
    int   w;
    int   word;
    int   lat;
    int   weLow;
    bit   done;
    bit   hi;
    obs_t o;
    w     = waitOf(s);
    word  = modelWord(a);
    lat   = 0;
    weLow = 0;
    done  = 0;
    setReq(s, re, we, a, d);
    if (fromDone) tick(); else #1;
    o = snap(s);
    checkOutput("readyLowCycle0", 32'(o.ready), 32'd0);
    while (!done && lat < 4 * w + 8) begin
      tick();
      lat++;
      o = snap(s);
      if (o.ready) begin
        done = 1;
      end else if (lat <= 2 * w) begin
        hi = (lat > w);
        checkOutput("sramAddr", 32'(o.addr), 32'(word * 2 + int'(hi)));
        if (we) begin
          checkOutput("dqOut", 32'(o.dq), hi ? 32'(d[31:16]) : 32'(d[15:0]));
          checkOutput("dqOeWrite", 32'(o.oe), 32'd1);
        end else begin
          checkOutput("dqOeRead", 32'(o.oe), 32'd0);
        end
        if (!o.weN) weLow++;
      end
    end
    checkOutput("latency", 32'(lat), 32'(1 + 2 * w));
    if (we) begin
      shadow[s][word] = d;
      checkOutput("weLowCycles", 32'(weLow), 32'(2 * w));
      checkOutput("sramWord", {sramRd(s, 2 * word + 1), sramRd(s, 2 * word)}, d);
    end else begin
      lastRead[s] = shadow[s][word];
    end
    checkOutput("readData", o.rdata, lastRead[s]);
  endtask

  task automatic checkIdle(input int s);
    obs_t o;
    setReq(s, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    o = snap(s);
    checkOutput("idleReady", 32'(o.ready), 32'd1);
    checkOutput("idleWeN", 32'(o.weN), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    obs_t        o;
    int          prevS;
    int          s;
    int          op;
    bit          b2b;
    logic [31:0] a;
    logic [31:0] d;

    rst   = 1'b1;
    preWe = 1'b0;
    preAddr = '0;
    preData0 = '0;
    preData1 = '0;
    setReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    setReq(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 128; i++) begin
      pre0[i] = (i == 0) ? 16'hBEEF : (i == 1) ? 16'hDEAD : 16'($urandom);
      pre1[i] = (i == 0) ? 16'hBEEF : (i == 1) ? 16'hDEAD : 16'($urandom);
      preWe = 1'b1; preAddr = 18'(i); preData0 = pre0[i]; preData1 = pre1[i];
      tick();
    end
    preWe = 1'b0;
    for (int wd = 0; wd < 64; wd++) begin
      shadow[0][wd] = {pre0[2 * wd + 1], pre0[2 * wd]};
      shadow[1][wd] = {pre1[2 * wd + 1], pre1[2 * wd]};
    end
    lastRead[0] = 32'd0;
    lastRead[1] = 32'd0;

    // Reset state of both instances.
    for (int k = 0; k < 2; k++) begin
      o = snap(k);
      checkOutput("rstReady", 32'(o.ready), 32'd1);
      checkOutput("rstReadData", o.rdata, 32'd0);
      checkOutput("rstSramAddr", 32'(o.addr), 32'd0);
      checkOutput("rstDqOut", 32'(o.dq), 32'd0);
      checkOutput("rstDqOe", 32'(o.oe), 32'd0);
      checkOutput("rstWeN", 32'(o.weN), 32'd1);
    end
    setReq(0, 1'b1, 1'b0, BASE, 32'd0);
    #1;
    o = snap(0);
    checkOutput("rstReadyWithReq", 32'(o.ready), 32'd0);
    setReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Directed: preloaded read, write then read back, both enables, wrapped address.
    applyStimulus(0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    checkOutput("readDeadBeef", busIf0.read_data, 32'hDEADBEEF);
    checkIdle(0);
    applyStimulus(0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 1'b0);
    checkOutput("sramHw4", 32'(sram0[4]), 32'h5678);
    checkOutput("sramHw5", 32'(sram0[5]), 32'h1234);
    checkIdle(0);
    applyStimulus(0, 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
    checkOutput("readBack", busIf0.read_data, 32'h12345678);
    checkIdle(0);
    applyStimulus(0, 1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b0);
    checkOutput("bothEnReadUnchanged", busIf0.read_data, 32'h12345678);
    checkOutput("bothEnWritten", {sram0[3], sram0[2]}, 32'hCAFEF00D);
    checkIdle(0);
    applyStimulus(0, 1'b0, 1'b1, 32'd0, 32'hA5A5_5A5A, 1'b0);
    checkOutput("wrapHwLo", 32'(sram0[18'h3FE00]), 32'h5A5A);
    checkIdle(0);
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    checkIdle(0);

    // Directed back-to-back reads on the single-wait instance.
    applyStimulus(1, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    checkOutput("b2bFirst", busIf1.read_data, 32'hDEADBEEF);
    applyStimulus(1, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b1);
    checkIdle(1);
    for (int k = 0; k < 5; k++) checkIdle(1);

    // Random mix of reads, writes and both-enables, sometimes chained back-to-back.
    prevS = 0;
    for (int n = 0; n < 60; n++) begin
      b2b = (n != 0) && ($urandom_range(0, 2) == 0);
      if (b2b) begin
        s = prevS;
      end else begin
        if (n != 0) checkIdle(prevS);
        repeat ($urandom_range(0, 2)) tick();
        s = int'($urandom_range(0, 1));
      end
      op = int'($urandom_range(0, 2));
      a  = BASE + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
      d  = $urandom;
      applyStimulus(s, op != 1, op != 0, a, d, b2b);
      prevS = s;
    end
    checkIdle(prevS);

    // Reset during the high write phase aborts the access.
    setReq(0, 1'b0, 1'b1, 32'd1040, 32'h0BAD_F00D);
    #1;
    tick();
    tick();
    tick();
    o = snap(0);
    checkOutput("wrHiWeN", 32'(o.weN), 32'd0);
    checkOutput("wrHiAddr", 32'(o.addr), 32'd9);
    rst = 1'b1;
    tick();
    o = snap(0);
    checkOutput("abortWeN", 32'(o.weN), 32'd1);
    checkOutput("abortDqOe", 32'(o.oe), 32'd0);
    checkOutput("abortReadData", o.rdata, 32'd0);
    checkOutput("abortSramAddr", 32'(o.addr), 32'd0);
    checkOutput("abortReadyReqHeld", 32'(o.ready), 32'd0);
    rst = 1'b0;
    setReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    o = snap(0);
    checkOutput("abortReadyIdle", 32'(o.ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
